hs_elastic_fifo: RTL
====================

Name: hs_elastic_fifo

Overview:
- Elastic buffer inserted between an arf output port (e.g. dout_req_4/dout_ack_4/dout_4) and its consumer, or between a producer and an arf input port.
- Upstream side acts as a requester: it drives req and receives a one-cycle ack with data.
- Downstream side acts as a responder: it receives req and returns a one-cycle ack with data.
- Decouples producer and consumer stalls. Provides push/pop counters and occupancy for throughput measurement in benches.

Parameters:
- data_width, 32, width of the data word.
- depth, 4, number of storage entries; power of two, minimum 2.
- ptr_width, $clog2(depth), read/write pointer width (derived, do not override).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- din_req  output  1  request to upstream; registered.
- din_ack  input  1  upstream ack, one-cycle pulse; din is valid in the same cycle.
- din  input  data_width  upstream data.
- dout_req  input  1  request from downstream consumer.
- dout_ack  output  1  ack to downstream, one-cycle pulse; registered.
- dout  output  data_width  data to downstream; registered, valid while dout_ack=1 and held afterwards.
- occupancy  output  ptr_width+1  number of stored words, 0..depth.
- push_count  output  32  total words accepted from upstream.
- pop_count  output  32  total words delivered downstream.
- overflow  output  1  sticky flag: din_ack arrived while the FIFO was full.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - Forces din_req=0, dout_ack=0, dout=0, occupancy=0, pointers=0, push_count=0, pop_count=0, overflow=0.
  - Stored data is discarded.
  - First din_req rise occurs on the first posedge after rst deasserts.
- Storage: circular array. wr_ptr and rd_ptr are ptr_width bits and wrap from depth-1 to 0. occupancy is a separate counter.
- Upstream (push) side, evaluated at each posedge:
  - If din_ack=1 and occupancy<depth: write din at wr_ptr, increment wr_ptr, increment push_count, set din_req<=0.
  - If din_ack=1 and occupancy==depth: drop the word, set overflow<=1, set din_req<=0.
  - Else if din_ack=0: din_req<=1 when occupancy<depth, otherwise din_req<=0.
  - Consequence: din_req is low for exactly one cycle after each accepted ack. Maximum upstream rate is one word per 2 cycles, matching the producer rule "ack only when req & ~ack".
- Downstream (pop) side, evaluated at each posedge:
  - If dout_req=1, dout_ack=0 and occupancy>0: dout<=mem[rd_ptr], dout_ack<=1, increment rd_ptr, increment pop_count.
  - Otherwise dout_ack<=0 and dout holds its value.
  - Maximum downstream rate is one word per 2 cycles.
- Pop decisions use occupancy as registered at the start of the cycle. A word pushed in cycle N is first poppable at posedge N+1 (first-word latency: 1 cycle from din_ack sample to dout_ack).
- Simultaneous push and pop in the same cycle: occupancy unchanged. Both pointers advance.
- Full (occupancy==depth) with a pop in the same cycle: the pop proceeds. A din_ack in that same cycle is still treated as overflow, because the full check uses registered occupancy.
- Empty (occupancy==0) with dout_req=1: no ack. A word pushed in this cycle is delivered next cycle.
- Counters: push_count and pop_count wrap modulo 2^32. overflow clears only on rst.
- Ordering: strict FIFO. Data is never modified.

Test Plan:
1. Reset, then an incrementing producer (0,1,2,…) with fail rate 0 and a consumer with fail rate 0, depth=4, 100 words → consumer receives 0..99 in order; push_count=pop_count=100; overflow=0; occupancy ≤1 throughout.
2. Downstream dout_req held 0, upstream acks 4 words (10,11,12,13) → occupancy=4; din_req=0 from the cycle after the 4th ack; no dout_ack. Then dout_req=1 → dout 10,11,12,13 on alternating cycles, occupancy back to 0, din_req re-asserts.
3. FIFO full with din_req=0, bench forces din_ack=1 with din=99 → word dropped, overflow=1 and stays 1, occupancy stays 4, push_count unchanged.
4. occupancy=2, din_ack and a dout_req pop in the same cycle → occupancy stays 2; next dout is the older head word; pointers wrap correctly after 10 such cycles (wr_ptr and rd_ptr pass 3→0).
5. Assert rst mid-stream with occupancy=3 and dout_ack=1 → all outputs 0 immediately (asynchronously, before the next posedge). After release, the next word delivered is the first word pushed post-reset.
6. Producer and consumer fail rates of 30, 5000 words → no loss or duplication; pop_count=5000; data sequence contiguous.

Source files
------------

// File: rtl/hs_elastic_fifo.sv
// Elastic req/ack buffer: upstream requester side, downstream responder side,
// circular storage with a separate occupancy counter plus throughput counters.
module hs_elastic_fifo #(
    parameter int data_width = 32,
    parameter int depth      = 4,
    parameter int ptr_width  = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  din_req,
    input  logic                  din_ack,
    input  logic [data_width-1:0] din,
    input  logic                  dout_req,
    output logic                  dout_ack,
    output logic [data_width-1:0] dout,
    output logic [ptr_width:0]    occupancy,
    output logic [31:0]           push_count,
    output logic [31:0]           pop_count,
    output logic                  overflow
);

    localparam int occ_width = ptr_width + 1;
    localparam logic [occ_width-1:0] occ_full = occ_width'(depth);
    localparam logic [occ_width-1:0] occ_one  = occ_width'(1);
    localparam logic [ptr_width-1:0] ptr_one  = ptr_width'(1);

    logic [data_width-1:0] mem [depth];
    logic [ptr_width-1:0]  wr_ptr;
    logic [ptr_width-1:0]  rd_ptr;
    logic                  push;
    logic                  pop;

    // Both decisions use the occupancy registered at the start of the cycle,
    // so a word pushed now is not poppable until the next edge and a full
    // buffer still drops an ack even if a pop frees a slot in the same cycle.
    assign push = din_ack && (occupancy < occ_full);
    assign pop  = dout_req && !dout_ack && (occupancy != '0);

    // Storage array; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Upstream handshake, overflow flag, write pointer and push counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_req    <= 1'b0;
            wr_ptr     <= '0;
            push_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (din_ack) begin
                din_req <= 1'b0;
                if (push) begin
                    wr_ptr     <= wr_ptr + ptr_one;
                    push_count <= push_count + 32'd1;
                end else begin
                    overflow <= 1'b1;
                end
            end else begin
                din_req <= (occupancy < occ_full);
            end
        end
    end

    // Downstream handshake: one-cycle ack with registered data held afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_ack  <= 1'b0;
            dout      <= '0;
            rd_ptr    <= '0;
            pop_count <= '0;
        end else begin
            if (pop) begin
                dout      <= mem[rd_ptr];
                dout_ack  <= 1'b1;
                rd_ptr    <= rd_ptr + ptr_one;
                pop_count <= pop_count + 32'd1;
            end else begin
                dout_ack <= 1'b0;
            end
        end
    end

    // Occupancy counter; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occupancy <= occupancy + occ_one;
                2'b01:   occupancy <= occupancy - occ_one;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule
